// File: rtl/aes_kexp_iter_pkg.sv
// aes_const: shared constants, types and helpers for the iterative AES
// key-expansion block.
//   Nb        - words per AES state column block (always 4)
//   MAX_WORDS - size of the expanded-key store (AES-256 schedule)
//   aes_mode_e     - key-length selector as presented on the mode port
//   kexp_state_e   - controller states
//   nk_of/nr_of/words_of/last_word - per-mode schedule geometry
//   xtime     - multiply-by-x in GF(2^8), used to step rcon
package aes_const;

  localparam int unsigned Nb        = 4;
  localparam int unsigned MAX_WORDS = 60;

  typedef enum logic [1:0] {
    MODE_128  = 2'd0,
    MODE_192  = 2'd1,
    MODE_256  = 2'd2,
    MODE_RSVD = 2'd3
  } aes_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } kexp_state_e;

  function automatic logic [3:0] nk_of(aes_mode_e m);
    case (m)
      MODE_128: return 4'd4;
      MODE_192: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(aes_mode_e m);
    case (m)
      MODE_128: return 4'd10;
      MODE_192: return 4'd12;
      default:  return 4'd14;
    endcase
  endfunction

  // Total schedule length in words: Nb*(Nr+1) = 44/52/60.
  function automatic logic [5:0] words_of(aes_mode_e m);
    return 6'(Nb * (32'(nr_of(m)) + 32'd1));
  endfunction

  function automatic logic [5:0] last_word(aes_mode_e m);
    return words_of(m) - 6'd1;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_kexp_word.sv
// aes_kexp_word: combinational next-word function of the AES key schedule.
//   w_prev - w[i-1]
//   w_back - w[i-Nk]
//   rcon   - current round constant (applied only when rot=1)
//   rot    - i % Nk == 0: RotWord + SubWord + rcon
//   sub    - AES-256 i % 8 == 4: SubWord only
//   sbox   - forward S-box table
//   w_next - w[i]
module aes_kexp_word (
  input  logic [31:0] w_prev,
  input  logic [31:0] w_back,
  input  logic [7:0]  rcon,
  input  logic        rot,
  input  logic        sub,
  input  logic [7:0]  sbox [0:255],
  output logic [31:0] w_next
);

  logic [31:0] t_rot;
  logic [31:0] t_sub;
  logic [31:0] t_mix;

  always_comb begin
    t_rot  = rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    t_sub  = {sbox[t_rot[31:24]], sbox[t_rot[23:16]],
              sbox[t_rot[15:8]],  sbox[t_rot[7:0]]};
    t_mix  = w_prev;
    if (rot) begin
      t_mix = t_sub ^ {rcon, 24'h000000};
    end else if (sub) begin
      t_mix = t_sub;
    end
    w_next = w_back ^ t_mix;
  end

endmodule

// File: rtl/aes_kexp_iter.sv
// aes_kexp_iter: iterative AES-128/192/256 key expansion, one schedule word
// per clock, with an internal 60-word store and a registered read port.
//   clock      - sole clock, rising edge
//   reset      - asynchronous, active low
//   start      - request expansion (taken only while ready=1 and mode!=3)
//   ready      - idle and able to accept start
//   mode       - key length 0=128, 1=192, 2=256, 3=reserved (sampled on accept)
//   Key        - key bytes, Key[0] first (sampled on accept)
//   SBox       - forward S-box table
//   zeroize    - (AES_KEXP_ZEROIZE_EN only) clear store, abort, drop keys_valid
//   done       - one-cycle pulse once the final word has been written
//   keys_valid - schedule complete and intact
//   nr         - round count of the latched mode
//   rd_addr    - schedule word index
//   rd_data    - word at rd_addr, one cycle later; 0 beyond the schedule
// Optional feature macro: AES_KEXP_ZEROIZE_EN.
module aes_kexp_iter
  import aes_const::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic [1:0]  mode,
  input  logic [7:0]  Key [0:31],
  input  logic [7:0]  SBox [0:255],
`ifdef AES_KEXP_ZEROIZE_EN
  input  logic        zeroize,
`endif
  output logic        done,
  output logic        keys_valid,
  output logic [3:0]  nr,
  input  logic [5:0]  rd_addr,
  output logic [31:0] rd_data
);

  kexp_state_e state_q, state_d;
  aes_mode_e   mode_q;
  aes_mode_e   mode_in;
  logic [5:0]  idx_q;
  logic [3:0]  kpos_q;      // i % Nk, tracked incrementally
  logic [7:0]  rcon_q;
  logic        done_q;
  logic        kv_q;
  logic        accept;
  logic        last_wr;
  logic [5:0]  nk6;
  logic [31:0] w_next;
  logic [31:0] mem [0:MAX_WORDS-1];

  assign mode_in    = aes_mode_e'(mode);
  assign nk6        = {2'b00, nk_of(mode_q)};
  assign ready      = (state_q == ST_IDLE);
  assign done       = done_q;
  assign keys_valid = kv_q;
  assign nr         = nr_of(mode_q);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (mode_in != MODE_RSVD)) begin
          accept  = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (idx_q == last_word(mode_q)) begin
          last_wr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef AES_KEXP_ZEROIZE_EN
    if (zeroize) begin
      accept  = 1'b0;
      last_wr = 1'b0;
      state_d = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // done/keys_valid are registered on the edge that commits the last word,
  // so they are visible in the cycle after that word was computed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_128;
      idx_q  <= '0;
      kpos_q <= '0;
      rcon_q <= 8'h01;
      done_q <= 1'b0;
      kv_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
`ifdef AES_KEXP_ZEROIZE_EN
      if (zeroize) begin
        idx_q  <= '0;
        kpos_q <= '0;
        rcon_q <= 8'h01;
        kv_q   <= 1'b0;
      end else
`endif
      if (accept) begin
        mode_q <= mode_in;
        idx_q  <= {2'b00, nk_of(mode_in)};
        kpos_q <= '0;
        rcon_q <= 8'h01;
        kv_q   <= 1'b0;
      end else if (state_q == ST_EXPAND) begin
        idx_q  <= idx_q + 6'd1;
        kpos_q <= (kpos_q == nk_of(mode_q) - 4'd1) ? '0 : kpos_q + 4'd1;
        if (kpos_q == 4'd0) begin
          rcon_q <= xtime(rcon_q);
        end
        if (last_wr) begin
          done_q <= 1'b1;
          kv_q   <= 1'b1;
        end
      end
    end
  end

  aes_kexp_word u_word (
    .w_prev (mem[idx_q - 6'd1]),
    .w_back (mem[idx_q - nk6]),
    .rcon   (rcon_q),
    .rot    (kpos_q == 4'd0),
    .sub    ((mode_q == MODE_256) && (kpos_q == 4'd4)),
    .sbox   (SBox),
    .w_next (w_next)
  );

  // Store has no reset: its contents are meaningless until an expansion
  // completes, and keys_valid/rd limit already gate its use.
  always_ff @(posedge clock) begin
`ifdef AES_KEXP_ZEROIZE_EN
    if (zeroize) begin
      for (int unsigned j = 0; j < MAX_WORDS; j++) begin
        mem[6'(j)] <= '0;
      end
    end else
`endif
    if (accept) begin
      for (int unsigned j = 0; j < 8; j++) begin
        if (j < 32'(nk_of(mode_in))) begin
          mem[6'(j)] <= {Key[5'(4*j)], Key[5'(4*j+1)],
                         Key[5'(4*j+2)], Key[5'(4*j+3)]};
        end
      end
    end else if (state_q == ST_EXPAND) begin
      mem[idx_q] <= w_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_addr < words_of(mode_q)) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_aes_kexp_iter.sv
`timescale 1ns/1ps
module tb_aes_kexp_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  key  [0:31];
  logic [7:0]  sbox [0:255];
  logic        ready, done, keys_valid;
  logic [3:0]  nr;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        zin;
`ifdef AES_KEXP_ZEROIZE_EN
  logic        zeroize;
  assign zeroize = zin;
`endif

  always #5 clock = ~clock;

  aes_kexp_iter dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .ready      (ready),
    .mode       (mode),
    .Key        (key),
    .SBox       (sbox),
`ifdef AES_KEXP_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .done       (done),
    .keys_valid (keys_valid),
    .nr         (nr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model (FIPS-197 algorithm level) -------------
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subword(logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  logic [31:0] m_new [0:59];

  function automatic void model_expand(int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    int total;
    total = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < 60; i++) m_new[i] = '0;
    for (int i = 0; i < nk; i++)
      m_new[i] = {key[4*i], key[4*i+1], key[4*i+2], key[4*i+3]};
    for (int i = nk; i < total; i++) begin
      t = m_new[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subword(t);
      end
      m_new[i] = m_new[i-nk] ^ t;
    end
  endfunction

  // Observable behaviour: busy span, store contents known to the bench,
  // and the registered read.
  bit          m_busy, m_done, m_kv, m_rdk;
  int          m_mode, m_next, m_last;
  logic [31:0] m_w [0:59];
  bit          m_known [0:59];
  logic [31:0] m_rd;

  function automatic int words_for(int md);
    return 4 * (4 + 2 * md + 7);
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_kv = 0; m_mode = 0;
    m_rd = '0; m_rdk = 1;
    for (int j = 0; j < 60; j++) m_known[j] = 0;
  endfunction

  function automatic void model_edge();
    int nk;
    if (!reset) begin
      model_reset();
      return;
    end
    if (int'(rd_addr) >= words_for(m_mode)) begin
      m_rd = '0; m_rdk = 1;
    end else begin
      m_rd = m_w[rd_addr]; m_rdk = m_known[rd_addr];
    end
    m_done = 0;
    if (zin) begin
      for (int j = 0; j < 60; j++) begin m_w[j] = '0; m_known[j] = 1; end
      m_busy = 0; m_kv = 0;
    end else if (!m_busy) begin
      if (start && mode != 2'd3) begin
        m_mode = int'(mode);
        nk = 4 + 2 * m_mode;
        model_expand(nk);
        for (int j = 0; j < nk; j++) begin m_w[j] = m_new[j]; m_known[j] = 1; end
        m_next = nk;
        m_last = words_for(m_mode) - 1;
        m_busy = 1; m_kv = 0;
      end
    end else begin
      m_w[m_next] = m_new[m_next];
      m_known[m_next] = 1;
      if (m_next == m_last) begin
        m_busy = 0; m_done = 1; m_kv = 1;
      end
      m_next++;
    end
  endfunction

  // -------------------------- per-cycle comparison --------------------------
  always @(negedge clock) begin
    if (chk_on) begin
      check("ready", 32'(ready), 32'(!m_busy));
      check("done", 32'(done), 32'(m_done));
      check("keys_valid", 32'(keys_valid), 32'(m_kv));
      check("nr", 32'(nr), 32'(10 + 2 * m_mode));
      if (m_rdk) check("rd_data", rd_data, m_rd);
    end
  end

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #2;
  endtask

  task automatic load_key(logic [255:0] kbits);
    for (int j = 0; j < 32; j++) key[j] = kbits[255-8*j -: 8];
  endtask

  // Accept edge opens cycle 1; done must be seen high in cycle exp_cyc.
  task automatic run_fips(string tag, int md, logic [255:0] kbits,
                          int pa, logic [31:0] ea, int pb, logic [31:0] eb,
                          int exp_cyc, int poke);
    int got;
    load_key(kbits);
    mode = 2'(md); start = 1; rd_addr = '0;
    cycle();
    start = 0;
    got = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (done) begin got = n; break; end
      start = (n == poke);
      if (n == poke) mode = 2'd2;
      rd_addr = 6'($urandom_range(0, 63));
      cycle();
    end
    start = 0;
    check({tag, " done cycle"}, got, exp_cyc);
    check({tag, " model w[a]"}, m_new[pa], ea);
    check({tag, " model w[b]"}, m_new[pb], eb);
    rd_addr = 6'(pa);
    cycle();
    @(negedge clock);
    check({tag, " rd w[a]"}, rd_data, ea);
    rd_addr = 6'(pb);
    cycle();
    @(negedge clock);
    check({tag, " rd w[b]"}, rd_data, eb);
  endtask

  logic [255:0] k128, k192, k256;
  int seen;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; start = 0; mode = '0; rd_addr = '0; zin = 0;
    for (int j = 0; j < 32; j++) key[j] = '0;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    build_sbox();
    model_reset();
    check("sbox[00]", 32'(sbox[8'h00]), 32'h63);
    check("sbox[01]", 32'(sbox[8'h01]), 32'h7c);
    check("sbox[53]", 32'(sbox[8'h53]), 32'hed);

    cycle();
    chk_on = 1;
    cycle();
    @(negedge clock);
    check("reset ready", 32'(ready), 32'h1);
    check("reset keys_valid", 32'(keys_valid), 32'h0);
    check("reset nr", 32'(nr), 32'd10);
    check("reset rd_data", rd_data, 32'h0);
    cycle();
    reset = 1;
    cycle();

    // reserved mode is ignored
    mode = 2'd3; start = 1;
    cycle();
    start = 0;
    @(negedge clock);
    check("mode3 ready", 32'(ready), 32'h1);
    cycle();

    run_fips("aes128", 0, k128, 4, 32'ha0fafe17, 43, 32'hb6630ca6, 41, 5);
    rd_addr = 6'd50;
    cycle();
    @(negedge clock);
    check("aes128 rd 50", rd_data, 32'h0);
    cycle();
    run_fips("aes192", 1, k192, 6, 32'hfe0c91f7, 51, 32'h01002202, 47, 0);
    cycle();
    run_fips("aes256", 2, k256, 8, 32'h9ba35411, 59, 32'h706c631e, 53, 0);
    cycle();

    // reset in cycle 20 of an AES-256 run
    load_key(k256);
    mode = 2'd2; start = 1;
    cycle();
    start = 0;
    repeat (19) cycle();
    reset = 0;
    model_reset();
    @(negedge clock);
    check("abort ready", 32'(ready), 32'h1);
    check("abort keys_valid", 32'(keys_valid), 32'h0);
    check("abort done", 32'(done), 32'h0);
    cycle(); cycle();
    reset = 1;
    seen = 0;
    repeat (60) begin
      @(negedge clock);
      if (done) seen = 1;
      cycle();
    end
    check("abort no done", seen, 0);
    run_fips("rerun256", 2, k256, 8, 32'h9ba35411, 59, 32'h706c631e, 53, 0);
    cycle();

`ifdef AES_KEXP_ZEROIZE_EN
    run_fips("pre-zero", 0, k128, 4, 32'ha0fafe17, 43, 32'hb6630ca6, 41, 0);
    zin = 1; start = 1; mode = 2'd0;
    cycle();
    zin = 0; start = 0;
    @(negedge clock);
    check("zero keys_valid", 32'(keys_valid), 32'h0);
    check("zero ready", 32'(ready), 32'h1);
    for (int a = 0; a < 60; a++) begin
      rd_addr = 6'(a);
      cycle();
      @(negedge clock);
      check("zero rd", rd_data, 32'h0);
      check("zero idle", 32'(ready), 32'h1);
    end
    cycle();
`endif

    // randomized traffic: random keys (changing while busy), modes incl. 3,
    // restarts while busy and in the done cycle, random reads
    for (int r = 0; r < 40; r++) begin
      for (int j = 0; j < 32; j++) key[j] = 8'($urandom);
      mode = 2'($urandom_range(0, 3)); start = 1;
      cycle();
      repeat ($urandom_range(30, 70)) begin
        start   = ($urandom_range(0, 2) == 0);
        mode    = 2'($urandom_range(0, 3));
        rd_addr = 6'($urandom_range(0, 63));
        key[$urandom_range(0, 31)] = 8'($urandom);
`ifdef AES_KEXP_ZEROIZE_EN
        zin = ($urandom_range(0, 63) == 0);
`endif
        cycle();
      end
      start = 0; zin = 0;
    end
    repeat (70) begin
      rd_addr = 6'($urandom_range(0, 63));
      cycle();
    end
    @(negedge clock);
    chk_on = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
